// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared 7-segment definitions: active-high lit patterns in {A,B,C,D,E,F,G} order
// (A is bit 6, G is bit 0), reused by every display block.
package seven_seg_scan_driver_pkg;

    localparam logic [6:0] SEG7_OFF = 7'h00;

    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] seg7_lit(input logic [3:0] nibble);
        return SEG7_HEX[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle: hex word, load strobe, live per-digit controls, and the pin outputs.
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, load, digit_en, dp_in,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, load, digit_en, dp_in,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_seg7
    import seven_seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = seg7_lit(nibble);
endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with dead-time, blanking, leading-zero
// suppression and a frame-aligned double buffer.
module seven_seg_scan_driver
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
)(
    input logic                   clk,
    input logic                   reset_n,
    seven_seg_scan_driver_if.slave bus
);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] SLOT_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF_PIN = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF_PIN  = DIG_ACTIVE_LOW ? '1 : '0;

    logic [PRE_W-1:0]        slot;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] staging;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;
    logic                    dead;
    logic                    boundary;

    assign dead     = (slot == '0);
    assign boundary = dead && (idx == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot <= '0;
            idx  <= '0;
        end else if (slot == SLOT_LAST) begin
            slot <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    // A load landing on the boundary bypasses staging so it shows in that same frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (boundary) begin
            if (bus.load) begin
                shadow  <= bus.value;
                staging <= bus.value;
            end else if (pending) begin
                shadow <= staging;
            end
            pending <= 1'b0;
        end else if (bus.load) begin
            staging <= bus.value;
            pending <= 1'b1;
        end
    end

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    // Leading zeros are judged from the shadow word alone; digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib[i]   = shadow[4*i +: 4];
            zero_run = zero_run && (nib[i] == 4'h0);
            if (i > 0) lz_mask[i] = BLANK_LEADING && zero_run;
        end
    end

    logic [3:0]            cur_nib;
    logic [6:0]            cur_pat;
    logic                  lit;
    logic [6:0]            seg_lit;
    logic [NUM_DIGITS-1:0] an_hot;

    assign cur_nib = nib[idx];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nib),
        .seg    (cur_pat)
    );

    assign lit     = !dead && bus.digit_en[idx] && !lz_mask[idx];
    assign seg_lit = lit ? cur_pat : SEG7_OFF;

    always_comb begin
        an_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_hot[i] = !dead && (idx == IDX_W'(i));
        end
    end

    logic [6:0]            seg_p1;
    logic                  dp_p1;
    logic [NUM_DIGITS-1:0] an_p1;
    logic                  frame_done_p1;

    // ---- output register stage ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_p1        <= SEG_OFF_PIN;
            dp_p1         <= SEG_ACTIVE_LOW;
            an_p1         <= AN_OFF_PIN;
            frame_done_p1 <= 1'b0;
        end else begin
            seg_p1        <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
            dp_p1         <= (lit && bus.dp_in[idx]) ^ SEG_ACTIVE_LOW;
            an_p1         <= DIG_ACTIVE_LOW ? ~an_hot : an_hot;
            frame_done_p1 <= boundary;
        end
    end

    assign bus.seg        = seg_p1;
    assign bus.dp         = dp_p1;
    assign bus.an         = an_p1;
    assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench: NUM_DIGITS=4, SCAN_DIV=4, active-low; a second instance has BLANK_LEADING=0.
module tb_seven_seg_scan_driver;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] Z0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  dp_in = 4'h0;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();
    seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus0 ();

    assign bus.value     = value;
    assign bus.load      = load;
    assign bus.digit_en  = digit_en;
    assign bus.dp_in     = dp_in;
    assign bus0.value    = value;
    assign bus0.load     = load;
    assign bus0.digit_en = digit_en;
    assign bus0.dp_in    = dp_in;

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)
    ) dut_nolz (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 16-cycle frame starting at a boundary edge; segs/segs0 are {d3,d2,d1,d0}.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [27:0] segs0,
                               input logic [3:0] dpx, input int la1, input logic [15:0] lv1,
                               input int la2, input logic [15:0] lv2);
        for (int c = 0; c < 16; c++) begin
            int         d;
            int         s;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic [6:0] e_seg0;
            logic       e_dp;
            if (c == la1) begin value = lv1; load = 1'b1; end
            else if (c == la2) begin value = lv2; load = 1'b1; end
            tick();
            load = 1'b0;
            d = c / 4;
            s = c % 4;
            e_an   = (s == 0) ? 4'b1111 : ~(4'b0001 << d);
            e_seg  = (s == 0) ? BL : segs[d*7 +: 7];
            e_seg0 = (s == 0) ? BL : segs0[d*7 +: 7];
            e_dp   = (s == 0) ? 1'b1 : dpx[d];
            chk($sformatf("%s c%0d an/seg/dp/fd", tag, c),
                {19'd0, bus.an, bus.seg, bus.dp, bus.frame_done},
                {19'd0, e_an, e_seg, e_dp, (c == 0)});
            chk($sformatf("%s c%0d seg_nolz", tag, c), {25'd0, bus0.seg}, {25'd0, e_seg0});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("reset an/seg/dp/fd", {19'd0, bus.an, bus.seg, bus.dp, bus.frame_done},
            {19'd0, 4'b1111, BL, 1'b1, 1'b0});
        reset_n = 1'b1;

        // Test 1: empty shadow, only digit 0 shows "0"
        check_frame("t1f0", {BL, BL, BL, Z0}, {Z0, Z0, Z0, Z0}, 4'hF, -1, 16'h0, -1, 16'h0);
        check_frame("t1f1", {BL, BL, BL, Z0}, {Z0, Z0, Z0, Z0}, 4'hF, -1, 16'h0, -1, 16'h0);

        // Test 2: load 12AF mid-frame, shown from next frame
        check_frame("t2old", {BL, BL, BL, Z0}, {Z0, Z0, Z0, Z0}, 4'hF, 5, 16'h12AF, -1, 16'h0);
        check_frame("t2new", {S1, S2, SA, SF}, {S1, S2, SA, SF}, 4'hF, -1, 16'h0, -1, 16'h0);

        // Test 3: 0050 with and without leading-zero suppression
        check_frame("t3old", {S1, S2, SA, SF}, {S1, S2, SA, SF}, 4'hF, 3, 16'h0050, -1, 16'h0);
        check_frame("t3new", {BL, BL, S5, Z0}, {Z0, Z0, S5, Z0}, 4'hF, -1, 16'h0, -1, 16'h0);

        // Test 4: two loads in one frame, then a load on the boundary itself
        check_frame("t4old", {BL, BL, S5, Z0}, {Z0, Z0, S5, Z0}, 4'hF, 2, 16'h1111, 9, 16'h2222);
        check_frame("t4last", {S2, S2, S2, S2}, {S2, S2, S2, S2}, 4'hF, -1, 16'h0, -1, 16'h0);
        check_frame("t4bypass", {S4, S3, S2, S1}, {S4, S3, S2, S1}, 4'hF, 0, 16'h4321, -1, 16'h0);

        // Test 5: digit 2 disabled but scanned, decimal point on digit 0
        digit_en = 4'b1011;
        dp_in    = 4'b0001;
        check_frame("t5", {S4, BL, S2, S1}, {S4, BL, S2, S1}, 4'b1110, -1, 16'h0, -1, 16'h0);
        digit_en = 4'hF;
        dp_in    = 4'h0;

        // Test 6: asynchronous reset while digit 2 is lit
        for (int c = 0; c < 10; c++) tick();
        chk("t6 pre-reset an/seg", {21'd0, bus.an, bus.seg}, {21'd0, 4'b1011, S3});
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6 async reset", {19'd0, bus.an, bus.seg, bus.dp, bus.frame_done},
            {19'd0, 4'b1111, BL, 1'b1, 1'b0});
        tick();
        chk("t6 held reset", {19'd0, bus.an, bus.seg, bus.dp, bus.frame_done},
            {19'd0, 4'b1111, BL, 1'b1, 1'b0});
        reset_n = 1'b1;
        check_frame("t6restart", {BL, BL, BL, Z0}, {Z0, Z0, Z0, Z0}, 4'hF, -1, 16'h0, -1, 16'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
